// File: rtl/ldl_cdc_pkg.sv
// ldl_cdc_pkg
// Shared helpers for the toggle-handshake CDC blocks.
// Provides a constant clog2 for pointer and count sizing, and a
// configuration check that the endpoints evaluate at elaboration.
package ldl_cdc_pkg;

    // Ceiling log2 usable in parameter and port-width expressions.
    function automatic int clog2_f(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // True when value is a non-zero power of two.
    function automatic bit is_pow2_f(input int value);
        return (value >= 32'sd1) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

    // FIFO depth must be a power of two of at least 2, and the
    // synchronizer needs at least two stages.
    function automatic bit fifo_cfg_ok_f(input int depth, input int sync);
        return is_pow2_f(depth) && (depth >= 32'sd2) && (sync >= 32'sd2);
    endfunction

endpackage

// File: rtl/ldl_sync_bit.sv
// ldl_sync_bit
// N-stage single-bit flop synchronizer with synchronous active-high reset.
// Shared by the toggle sink and the matching toggle source.
// Ports:
//   clk  - destination clock
//   rst  - synchronous reset, active-high
//   d    - asynchronous input bit
//   q    - synchronized output (last stage)
module ldl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous bit through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/ldl_cdc_toggle_sink.sv
// ldl_cdc_toggle_sink
// Receive endpoint of the two-phase (toggle) handshake. The synchronized
// request toggle is compared against the local ack toggle; a mismatch is a
// pending request whose payload is written into a small FIFO, and the ack
// toggles in the same edge. When the FIFO is full the ack is withheld, so
// the sender stalls instead of losing data.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   req_tgl   - request toggle from the remote domain (asynchronous)
//   req_data  - payload, held stable by the sender until acknowledged
//   ack_tgl   - acknowledge toggle, straight from a flop
//   m_valid / m_ready / m_data - downstream valid/ready stream (FIFO head)
//   count     - FIFO occupancy
//   busy      - request seen but not yet acknowledged
module ldl_cdc_toggle_sink
    import ldl_cdc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_tgl,
    input  logic [WIDTH-1:0]             req_data,
    output logic                         ack_tgl,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic [clog2_f(DEPTH+1)-1:0] count,
    output logic                         busy
);

    localparam int PTR_W = clog2_f(DEPTH);
    localparam int CNT_W = clog2_f(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    if (!fifo_cfg_ok_f(DEPTH, SYNC)) begin : g_cfg_err
        $error("ldl_cdc_toggle_sink: DEPTH must be a power of 2 >= 2 and SYNC >= 2");
    end

    logic                 req_s;
    logic                 ack_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_nxt_s;
    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic                 valid_s;
    logic                 pending_s;
    logic                 pop_s;
    logic                 push_s;
    logic [WIDTH-1:0]     head_s;

    ldl_sync_bit #(
        .STAGES (SYNC)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_s)
    );

    // Handshake and FIFO control terms. A push is allowed into a full FIFO
    // when a pop frees the head slot in the same edge.
    always_comb begin
        valid_s   = (count_r != '0);
        pending_s = req_s ^ ack_r;
        pop_s     = valid_s & m_ready;
        push_s    = pending_s & ((count_r < DEPTH_C) | pop_s);
    end

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and ack toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r    <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                ack_r    <= ~ack_r;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= req_data;
        end
    end

    // Head word is forced to zero while the FIFO is empty so the output
    // is defined out of reset even though storage is not cleared.
    always_comb begin
        if (valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign ack_tgl = ack_r;
    assign m_valid = valid_s;
    assign m_data  = head_s;
    assign count   = count_r;
    assign busy    = pending_s;

endmodule
